ddr_axi_master: RTL and testbench

AXI3 initiator (master) that drives the DDR memory controller's AXI3 slave port (S0_*) from a simple command/stream user interface.
- Serialises one transaction at a time: either a write burst (AW, then W, then B) or a read burst (AR, then R).
- Generates WLAST from a beat counter and checks RLAST against the same counter.
- A watchdog aborts a stalled transaction.
- Used by test traffic generators and the system DMA front end.

---
 rtl/ddr_axi_pkg.sv | 25 ++
 rtl/ddr_axi_if.sv | 62 ++++++
 rtl/ddr_axi_watchdog.sv | 36 +++
 rtl/ddr_axi_master.sv | 202 ++++++++++++++++++++
 tb/tb_ddr_axi_master.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_axi_pkg.sv
// Shared state type, AXI3 encodings and response helper for the DDR AXI
// initiator and its watchdog.
package ddr_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } axi_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    // Numerically larger AXI responses are the more severe ones.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_axi_if.sv
// AXI3 bus between the DDR AXI initiator and the DDR controller slave port.
interface ddr_axi_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [3:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;

    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic              WLAST;

    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [3:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;

    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic              RLAST;

    modport master (
        output AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
        input  AWREADY,
        output WDATA, WSTRB, WVALID, WLAST,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST,
        input  ARREADY,
        input  RDATA, RRESP, RVALID, RLAST,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
        output AWREADY,
        input  WDATA, WSTRB, WVALID, WLAST,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST,
        output ARREADY,
        output RDATA, RRESP, RVALID, RLAST,
        input  RREADY
    );

endinterface

// File: rtl/ddr_axi_watchdog.sv
// Stall watchdog: counts enabled cycles without a clear and pulses expire on
// the TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES = 0 disables it.
module ddr_axi_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_q;

            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    count_q <= '0;
                end else if (clear || !enable) begin
                    count_q <= '0;
                end else if (count_q != LIMIT) begin
                    count_q <= count_q + 1'b1;
                end
            end

            assign expire = enable && !clear && (count_q == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/ddr_axi_master.sv
// AXI3 initiator for the DDR controller slave port: one write (AW, W, B) or
// read (AR, R) burst at a time, driven from a command/stream user interface.
module ddr_axi_master
    import ddr_axi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,

    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    input  logic              wr_valid,
    output logic              wr_ready,

    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,

    output logic              done,
    output logic [1:0]        done_resp,
    output logic              done_err,

    ddr_axi_if.master         m0
);

    axi_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [3:0]        beat_q;
    logic              aw_valid_q;
    logic              ar_valid_q;
    logic              bready_q;
    logic [1:0]        resp_q;
    logic              err_q;

    logic              aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic              last_beat;
    logic              busy;
    logic              wd_clear;
    logic              wd_expire;
    logic [1:0]        r_resp_next;
    logic              r_err_next;

    always_comb begin
        aw_hs       = aw_valid_q & m0.AWREADY;
        ar_hs       = ar_valid_q & m0.ARREADY;
        w_hs        = (state_q == ST_W) & wr_valid & m0.WREADY;
        b_hs        = bready_q & m0.BVALID;
        r_hs        = (state_q == ST_R) & m0.RVALID & rd_ready;
        last_beat   = (beat_q == len_q);
        busy        = state_q inside {ST_AW, ST_W, ST_B, ST_AR, ST_R};
        wd_clear    = ~busy | aw_hs | ar_hs | w_hs | b_hs | r_hs;
        r_resp_next = resp_worst(resp_q, m0.RRESP);
        r_err_next  = err_q | (m0.RLAST != last_beat);
    end

    ddr_axi_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .clear   (wd_clear),
        .enable  (busy),
        .expire  (wd_expire)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            aw_valid_q <= 1'b0;
            ar_valid_q <= 1'b0;
            bready_q   <= 1'b0;
            resp_q     <= AXI_RESP_OKAY;
            err_q      <= 1'b0;
            done       <= 1'b0;
            done_resp  <= AXI_RESP_OKAY;
            done_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && wd_expire) begin
                aw_valid_q <= 1'b0;
                ar_valid_q <= 1'b0;
                bready_q   <= 1'b0;
                done       <= 1'b1;
                done_resp  <= AXI_RESP_SLVERR;
                done_err   <= 1'b1;
                state_q    <= ST_DONE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            addr_q <= cmd_addr & ~ADDR_W'(3);
                            len_q  <= cmd_len;
                            beat_q <= '0;
                            resp_q <= AXI_RESP_OKAY;
                            err_q  <= 1'b0;
                            if (cmd_write) begin
                                aw_valid_q <= 1'b1;
                                state_q    <= ST_AW;
                            end else begin
                                ar_valid_q <= 1'b1;
                                state_q    <= ST_AR;
                            end
                        end
                    end
                    ST_AW: begin
                        if (aw_hs) begin
                            aw_valid_q <= 1'b0;
                            state_q    <= ST_W;
                        end
                    end
                    ST_W: begin
                        if (w_hs) begin
                            if (last_beat) begin
                                bready_q <= 1'b1;
                                state_q  <= ST_B;
                            end else begin
                                beat_q <= beat_q + 1'b1;
                            end
                        end
                    end
                    ST_B: begin
                        if (b_hs) begin
                            bready_q  <= 1'b0;
                            done      <= 1'b1;
                            done_resp <= m0.BRESP;
                            done_err  <= err_q;
                            state_q   <= ST_DONE;
                        end
                    end
                    ST_AR: begin
                        if (ar_hs) begin
                            ar_valid_q <= 1'b0;
                            state_q    <= ST_R;
                        end
                    end
                    ST_R: begin
                        // Completion follows the beat counter; RLAST only feeds the error flag.
                        if (r_hs) begin
                            resp_q <= r_resp_next;
                            err_q  <= r_err_next;
                            if (last_beat) begin
                                done      <= 1'b1;
                                done_resp <= r_resp_next;
                                done_err  <= r_err_next;
                                state_q   <= ST_DONE;
                            end else begin
                                beat_q <= beat_q + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);

    assign m0.AWADDR  = addr_q;
    assign m0.AWVALID = aw_valid_q;
    assign m0.AWLEN   = len_q;
    assign m0.AWSIZE  = AXI_SIZE_4B;
    assign m0.AWBURST = AXI_BURST_INCR;

    assign m0.WDATA   = wr_data;
    assign m0.WSTRB   = wr_strb;
    assign m0.WVALID  = (state_q == ST_W) & wr_valid;
    assign m0.WLAST   = (state_q == ST_W) & last_beat;
    assign wr_ready   = (state_q == ST_W) & m0.WREADY;

    assign m0.BREADY  = bready_q;

    assign m0.ARADDR  = addr_q;
    assign m0.ARVALID = ar_valid_q;
    assign m0.ARLEN   = len_q;
    assign m0.ARSIZE  = AXI_SIZE_4B;
    assign m0.ARBURST = AXI_BURST_INCR;

    assign m0.RREADY  = (state_q == ST_R) & rd_ready;
    assign rd_valid   = (state_q == ST_R) & m0.RVALID;
    assign rd_data    = m0.RDATA;
    assign rd_last    = (state_q == ST_R) & last_beat;

endmodule

// File: tb/tb_ddr_axi_master.sv
// Bench for ddr_axi_master: a randomised AXI3 slave with its own memory, and a
// reference memory updated only from what the user side wrote.
module tb_ddr_axi_master;

    localparam int unsigned TO   = 16;
    localparam int          MEMW = 512;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_ready = 1'b0;
    logic        done;
    logic [1:0]  done_resp;
    logic        done_err;

    ddr_axi_if #(.ADDR_W(32)) m0 ();

    ddr_axi_master #(
        .TIMEOUT_CYCLES(TO),
        .ADDR_W        (32)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .rd_ready  (rd_ready),
        .done      (done),
        .done_resp (done_resp),
        .done_err  (done_err),
        .m0        (m0.master)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Slave memory (bus side) and reference memory (user side)
    logic [31:0] smem [MEMW];
    logic [31:0] rmem [MEMW];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];

    function automatic int widx(input logic [31:0] a, input int i);
        return int'(((a >> 2) + 32'(i)) % 32'(MEMW));
    endfunction

    function automatic logic rnd();
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Slave model state and controls
    logic [31:0] s_awaddr, s_raddr;
    int          s_awlen, s_wcnt, s_rlen, s_rbeat;
    bit          s_aw_ok, s_b_pend, s_r_act, r_shown;
    bit          never_b = 1'b0;
    int          rlast_at = -1;
    int          rerr_at = -1;
    logic [31:0] wlog_d [$];
    logic [3:0]  wlog_s [$];
    logic        wlog_l [$];

    task automatic slave_clear();
        s_aw_ok = 0; s_b_pend = 0; s_r_act = 0; r_shown = 0;
        s_wcnt = 0; s_rbeat = 0; s_awlen = 0; s_rlen = 0;
        m0.AWREADY = 0; m0.WREADY = 0; m0.BVALID = 0; m0.BRESP = 2'b00;
        m0.ARREADY = 0; m0.RVALID = 0; m0.RDATA = '0; m0.RRESP = 2'b00; m0.RLAST = 0;
    endtask

    initial begin
        slave_clear();
        forever begin
            @(negedge ACLK);
            m0.AWREADY = rnd();
            m0.ARREADY = rnd();
            m0.WREADY  = s_aw_ok ? rnd() : 1'b0;
            m0.BVALID  = s_b_pend && !never_b;
            m0.BRESP   = 2'b00;
            if (s_r_act) begin
                if (!r_shown) r_shown = rnd();
                m0.RVALID = r_shown;
                m0.RDATA  = smem[widx(s_raddr, s_rbeat)];
                m0.RRESP  = (s_rbeat == rerr_at) ? 2'b10 : 2'b00;
                m0.RLAST  = (s_rbeat == ((rlast_at >= 0) ? rlast_at : s_rlen));
            end else begin
                m0.RVALID = 0; m0.RLAST = 0; m0.RRESP = 2'b00;
            end
            #1;
            if (!ARESETn) begin
                slave_clear();
            end else begin
                if (m0.AWVALID && m0.AWREADY) begin
                    s_awaddr = m0.AWADDR; s_awlen = int'(m0.AWLEN); s_wcnt = 0; s_aw_ok = 1;
                end
                if (m0.WVALID && m0.WREADY) begin
                    for (int j = 0; j < 4; j++)
                        if (m0.WSTRB[j]) smem[widx(s_awaddr, s_wcnt)][8*j +: 8] = m0.WDATA[8*j +: 8];
                    wlog_d.push_back(m0.WDATA);
                    wlog_s.push_back(m0.WSTRB);
                    wlog_l.push_back(m0.WLAST);
                    if (s_wcnt == s_awlen) begin s_aw_ok = 0; s_b_pend = 1; end
                    s_wcnt++;
                end
                if (m0.BVALID && m0.BREADY) s_b_pend = 0;
                if (m0.ARVALID && m0.ARREADY) begin
                    s_r_act = 1; s_raddr = m0.ARADDR; s_rlen = int'(m0.ARLEN); s_rbeat = 0; r_shown = 0;
                end
                if (m0.RVALID && m0.RREADY) begin
                    r_shown = 0;
                    if (s_rbeat == s_rlen) s_r_act = 0;
                    s_rbeat++;
                end
            end
        end
    end

    // Present a command at a fresh negedge and check the address channel one cycle later.
    task automatic issue(input bit wr, input logic [31:0] a, input int len);
        @(negedge ACLK);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = 4'(len);
        @(negedge ACLK);
        cmd_valid = 0; cmd_addr = $urandom; cmd_len = 4'($urandom);
        if (wr) begin
            check("awvalid_n1", m0.AWVALID, 1);
            check("awaddr", m0.AWADDR, a & 32'hFFFF_FFFC);
            check("awlen", m0.AWLEN, len);
            check("awsize", m0.AWSIZE, 2);
            check("awburst", m0.AWBURST, 1);
        end else begin
            check("arvalid_n1", m0.ARVALID, 1);
            check("araddr", m0.ARADDR, a & 32'hFFFF_FFFC);
            check("arlen", m0.ARLEN, len);
            check("arsize", m0.ARSIZE, 2);
            check("arburst", m0.ARBURST, 1);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input bit expect_to);
        int idx = 0;
        int cyc = 0;
        int bready_cycles = 0;
        bit got_done = 0;
        bit data_ok = 1;
        bit last_ok = 1;
        wlog_d.delete(); wlog_s.delete(); wlog_l.delete();
        issue(1, a, len);
        while (!got_done && cyc < 400) begin
            if (idx <= len) begin
                wr_valid = rnd(); wr_data = wdat[idx]; wr_strb = wstb[idx];
            end else begin
                wr_valid = 0;
            end
            #2;
            if (m0.BREADY) bready_cycles++;
            if (done) got_done = 1;
            else begin
                if (wr_valid && wr_ready) idx++;
                @(negedge ACLK);
                cyc++;
            end
        end
        wr_valid = 0;
        check("wr_done_seen", got_done, 1);
        check("wr_done_resp", done_resp, expect_to ? 2 : 0);
        check("wr_done_err", done_err, expect_to ? 1 : 0);
        check("wr_bready_at_done", m0.BREADY, 0);
        if (expect_to) check("to_bready_cycles", bready_cycles, TO);
        check("w_beats", wlog_d.size(), len + 1);
        for (int i = 0; i < wlog_d.size() && i <= len; i++) begin
            if (wlog_d[i] !== wdat[i] || wlog_s[i] !== wstb[i]) data_ok = 0;
            if (wlog_l[i] !== (i == len)) last_ok = 0;
        end
        check("w_data", data_ok, 1);
        check("w_last", last_ok, 1);
        for (int i = 0; i <= len; i++)
            for (int j = 0; j < 4; j++)
                if (wstb[i][j]) rmem[widx(a, i)][8*j +: 8] = wdat[i][8*j +: 8];
        @(negedge ACLK);
        check("wr_done_1cyc", done, 0);
        check("wr_cmd_ready_after", cmd_ready, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input bit toggle,
                           input logic [1:0] eresp, input bit eerr);
        int beat = 0;
        int cyc = 0;
        bit got_done = 0;
        bit mirror_ok = 1;
        issue(0, a, len);
        while (!got_done && cyc < 400) begin
            rd_ready = toggle ? (cyc % 2 == 0) : rnd();
            #2;
            if (m0.RVALID && (m0.RREADY !== rd_ready)) mirror_ok = 0;
            if (done) got_done = 1;
            else begin
                if (rd_valid && rd_ready) begin
                    check("rd_data", rd_data, rmem[widx(a, beat)]);
                    check("rd_last", rd_last, beat == len);
                    beat++;
                end
                @(negedge ACLK);
                cyc++;
            end
        end
        rd_ready = 0;
        check("rd_done_seen", got_done, 1);
        check("rd_beats", beat, len + 1);
        check("rd_rready_mirror", mirror_ok, 1);
        check("rd_done_resp", done_resp, eresp);
        check("rd_done_err", done_err, eerr);
        @(negedge ACLK);
        check("rd_done_1cyc", done, 0);
        check("rd_cmd_ready_after", cmd_ready, 1);
    endtask

    task automatic reset_pulse();
        @(negedge ACLK);
        ARESETn = 0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1;
    endtask

    logic [31:0] ra;
    int          rl;
    int          k;
    bit          fired;

    initial begin
        for (int i = 0; i < MEMW; i++) begin
            rmem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
            smem[i] = rmem[i];
        end

        // Reset values, with user-side valid/ready high to expose ungated passthroughs
        wr_valid = 1; rd_ready = 1;
        repeat (3) @(negedge ACLK);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_awvalid", m0.AWVALID, 0);
        check("rst_arvalid", m0.ARVALID, 0);
        check("rst_wvalid", m0.WVALID, 0);
        check("rst_bready", m0.BREADY, 0);
        check("rst_rready", m0.RREADY, 0);
        check("rst_done", done, 0);
        check("rst_done_resp", done_resp, 0);
        check("rst_done_err", done_err, 0);
        wr_valid = 0; rd_ready = 0;
        ARESETn = 1;

        // Directed write then read-back
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'h1111_1111 * (i + 1); wstb[i] = 4'hF; end
        do_write(32'h0000_0040, 3, 0);
        do_read(32'h0000_0040, 3, 0, 2'b00, 0);

        // Single beat with unaligned address
        wdat[0] = $urandom; wstb[0] = 4'hF;
        do_write(32'h0000_0103, 0, 0);
        do_read(32'h0000_0100, 0, 0, 2'b00, 0);

        // 16-beat burst, read back with rd_ready toggling
        for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        do_write(32'h0000_0180, 15, 0);
        do_read(32'h0000_0180, 15, 1, 2'b00, 0);

        // Early RLAST and a SLVERR beat
        rlast_at = 2; rerr_at = 1;
        do_read(32'h0000_0040, 3, 0, 2'b10, 1);
        rlast_at = -1; rerr_at = -1;

        // Random traffic
        repeat (12) begin
            ra = $urandom_range(0, MEMW * 4 - 1);
            rl = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
                do_write(ra, rl, 0);
            end else begin
                do_read(ra, rl, 0, 2'b00, 0);
            end
        end

        // Watchdog abort while waiting for BVALID
        never_b = 1;
        for (int i = 0; i < 2; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        do_write(32'h0000_0300, 1, 1);
        never_b = 0;
        reset_pulse();

        // Reset asserted during the second W beat
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        issue(1, 32'h0000_0200, 3);
        k = 0; fired = 0;
        while (!fired && k < 100) begin
            wr_valid = 1; wr_data = wdat[0]; wr_strb = wstb[0];
            #2;
            if (wr_ready) fired = 1;
            @(negedge ACLK);
            k++;
        end
        check("rst_w_beat1_seen", fired, 1);
        wr_data = wdat[1];
        #2;
        check("rst_wvalid_before", m0.WVALID, 1);
        ARESETn = 0;
        #1;
        check("rst_mid_wvalid", m0.WVALID, 0);
        check("rst_mid_awvalid", m0.AWVALID, 0);
        check("rst_mid_wr_ready", wr_ready, 0);
        wr_valid = 0;
        repeat (3) begin
            @(negedge ACLK);
            check("rst_mid_no_done", done, 0);
        end
        ARESETn = 1;
        #2;
        check("rst_mid_cmd_ready", cmd_ready, 1);
        do_write(32'h0000_0200, 3, 0);
        do_read(32'h0000_0200, 3, 0, 2'b00, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
